// File: rtl/psum_drain_if.sv
// Column-bottom drain bus: psum ingress from the last PE plus the result valid/ready egress.
interface psum_drain_if #(
  parameter int unsigned COL_WIDTH = 11
);
  logic [2*COL_WIDTH-1:0] psum_in;
  logic                   psum_valid;
  logic                   psum_last;
  logic                   s_psum;
  logic [4:0]             shift;
  logic                   s_out;
  logic                   psum_ready;
  logic [7:0]             out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   overflow;

  modport master (
    output psum_in, psum_valid, psum_last, s_psum, shift, s_out, out_ready,
    input  psum_ready, out_data, out_valid, overflow
  );

  modport slave (
    input  psum_in, psum_valid, psum_last, s_psum, shift, s_out, out_ready,
    output psum_ready, out_data, out_valid, overflow
  );
endinterface

// File: rtl/psum_drain.sv
// Accumulates column psums across weight passes, requantizes finished sums to 8 bits
// and queues them in a small FIFO for the output buffer.
module psum_drain #(
  parameter int unsigned COL_WIDTH  = 11,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  psum_drain_if.slave  bus_if
);

  localparam int unsigned RND_W = ACC_WIDTH + 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic signed [RND_W-1:0] S8_MAX = RND_W'(127);
  localparam logic signed [RND_W-1:0] S8_MIN = RND_W'(-128);
  localparam logic signed [RND_W-1:0] U8_MAX = RND_W'(255);
  localparam logic signed [RND_W-1:0] ZERO   = '0;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] ext_psum;
  logic signed [ACC_WIDTH-1:0] total;
  logic        [RND_W-1:0]     rnd_add;
  logic signed [RND_W-1:0]     rounded;
  logic signed [RND_W-1:0]     shifted;
  logic        [7:0]           quant;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q, valid_q;
  logic             ovf_q, ovf_d;
  logic             push, pop;

  // Extend the incoming psum word to accumulator width.
  always_comb begin
    ext_psum = '0;
    if (bus_if.s_psum) begin
      ext_psum = ACC_WIDTH'($signed(bus_if.psum_in));
    end else begin
      ext_psum = ACC_WIDTH'(bus_if.psum_in);
    end
  end

  assign total = acc_q + ext_psum;

  // Round half up and shift in one extra bit so the rounding add never wraps.
  always_comb begin
    rnd_add = '0;
    if (bus_if.shift != 5'd0) begin
      rnd_add = RND_W'(1) << (bus_if.shift - 5'd1);
    end
    rounded = RND_W'(total) + rnd_add;
    shifted = rounded >>> bus_if.shift;
  end

  // Saturate: signed clamps to int8, unsigned clamps to uint8 with negatives to zero.
  always_comb begin
    quant = shifted[7:0];
    if (bus_if.s_out) begin
      if (shifted > S8_MAX) begin
        quant = 8'h7F;
      end else if (shifted < S8_MIN) begin
        quant = 8'h80;
      end
    end else begin
      if (shifted < ZERO) begin
        quant = 8'h00;
      end else if (shifted > U8_MAX) begin
        quant = 8'hFF;
      end
    end
  end

  assign push = bus_if.psum_valid & bus_if.psum_last & ready_q;
  assign pop  = valid_q & bus_if.out_ready;

  always_comb begin
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (bus_if.psum_valid) begin
      if (bus_if.psum_last) begin
        acc_d = '0;
        if (!ready_q) begin
          ovf_d = 1'b1;
        end
      end else begin
        acc_d = total;
      end
    end
  end

  // ready/valid are registered from the next count so neither depends on out_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
      ready_q <= (count_d < CNT_W'(FIFO_DEPTH));
      valid_q <= (count_d != '0);
      ovf_q   <= ovf_d;
      if (push) begin
        mem_q[wr_ptr_q] <= quant;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  assign bus_if.psum_ready = ready_q;
  assign bus_if.out_valid  = valid_q;
  assign bus_if.out_data   = mem_q[rd_ptr_q];
  assign bus_if.overflow   = ovf_q;

endmodule

// File: tb/tb_psum_drain.sv
// Self-checking bench for psum_drain: directed vector table, multi-cycle corner sequences
// and randomized traffic against a queue-based reference model.
module tb_psum_drain;

  localparam int unsigned COL_WIDTH  = 11;
  localparam int unsigned ACC_WIDTH  = 32;
  localparam int unsigned FIFO_DEPTH = 4;

  logic clk;
  logic rst;

  psum_drain_if #(.COL_WIDTH(COL_WIDTH)) bus ();

  psum_drain #(
    .COL_WIDTH (COL_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_if(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: accumulator value, queued results, sticky drop flag.
  longint     m_acc;
  logic [7:0] m_q[$];
  bit         m_ovf;

  typedef struct {
    logic [21:0] psum;
    bit          sp;
    logic [4:0]  sh;
    bit          so;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint wrap_acc(input longint x);
    logic signed [ACC_WIDTH-1:0] t;
    t = ACC_WIDTH'(x);
    return longint'(t);
  endfunction

  function automatic logic [7:0] m_requant(input longint total, input int sh, input bit so);
    longint r;
    r = total;
    if (sh > 0) r = r + (longint'(1) << (sh - 1));
    r = r >>> sh;
    if (so) begin
      if (r > 127) r = 127;
      else if (r < -128) r = -128;
    end else begin
      if (r < 0) r = 0;
      else if (r > 255) r = 255;
    end
    return 8'(r);
  endfunction

  // One clock with the given inputs; the model advances on the same edge, outputs checked #1 later.
  task automatic cyc(input bit v, input bit l, input logic [21:0] p, input bit sp,
                     input logic [4:0] sh, input bit so, input bit ordy);
    bit     was_ready;
    bit     do_pop;
    bit     do_push;
    longint e;
    longint t;
    logic [7:0] res;
    bus.psum_valid = v;
    bus.psum_last  = l;
    bus.psum_in    = p;
    bus.s_psum     = sp;
    bus.shift      = sh;
    bus.s_out      = so;
    bus.out_ready  = ordy;
    @(posedge clk);
    was_ready = (m_q.size() < FIFO_DEPTH);
    do_pop    = (m_q.size() != 0) && ordy;
    do_push   = 1'b0;
    res       = '0;
    e = sp ? longint'($signed(p)) : longint'(p);
    if (v) begin
      if (l) begin
        t = wrap_acc(m_acc + e);
        m_acc = 0;
        if (was_ready) begin
          do_push = 1'b1;
          res = m_requant(t, int'(sh), so);
        end else begin
          m_ovf = 1'b1;
        end
      end else begin
        m_acc = wrap_acc(m_acc + e);
      end
    end
    if (do_pop) void'(m_q.pop_front());
    if (do_push) m_q.push_back(res);
    #1;
    chk("out_valid", longint'(bus.out_valid), longint'(m_q.size() != 0));
    chk("psum_ready", longint'(bus.psum_ready), longint'(m_q.size() < FIFO_DEPTH));
    chk("overflow", longint'(bus.overflow), longint'(m_ovf));
    if (m_q.size() != 0) chk("out_data", longint'(bus.out_data), longint'(m_q[0]));
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.psum_valid = 1'b1;
    bus.psum_last  = 1'b1;
    bus.psum_in    = 22'd123;
    bus.out_ready  = 1'b0;
    @(posedge clk);
    m_acc = 0;
    m_q.delete();
    m_ovf = 1'b0;
    #1;
    rst            = 1'b0;
    bus.psum_valid = 1'b0;
    bus.psum_last  = 1'b0;
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_psum_ready", longint'(bus.psum_ready), 1);
    chk("rst_out_data", longint'(bus.out_data), 0);
    chk("rst_overflow", longint'(bus.overflow), 0);
  endtask

  initial begin
    logic [7:0] fill_exp [4];
    logic [21:0] rp;

    vecs[0]  = '{22'd640,         1'b1, 5'd4,  1'b0, 8'd40};
    vecs[1]  = '{22'd648,         1'b1, 5'd4,  1'b0, 8'd41};
    vecs[2]  = '{22'h3FFFCE,      1'b1, 5'd0,  1'b0, 8'd0};
    vecs[3]  = '{22'd20000,       1'b1, 5'd2,  1'b1, 8'd127};
    vecs[4]  = '{22'd20000,       1'b1, 5'd2,  1'b0, 8'd255};
    vecs[5]  = '{22'(-20000),     1'b1, 5'd2,  1'b1, 8'h80};
    vecs[6]  = '{22'h3FFFFF,      1'b0, 5'd16, 1'b0, 8'd64};
    vecs[7]  = '{22'(-20000),     1'b1, 5'd8,  1'b1, 8'hB2};
    vecs[8]  = '{22'h3FFFFF,      1'b1, 5'd0,  1'b1, 8'hFF};
    vecs[9]  = '{22'd5,           1'b1, 5'd31, 1'b1, 8'd0};
    vecs[10] = '{22'd3,           1'b1, 5'd1,  1'b1, 8'd2};
    vecs[11] = '{22'(-3),         1'b1, 5'd1,  1'b1, 8'hFF};
    vecs[12] = '{22'd7,           1'b1, 5'd0,  1'b1, 8'd7};

    rst            = 1'b1;
    bus.psum_in    = '0;
    bus.psum_valid = 1'b0;
    bus.psum_last  = 1'b0;
    bus.s_psum     = 1'b0;
    bus.shift      = '0;
    bus.s_out      = 1'b0;
    bus.out_ready  = 1'b0;
    m_acc = 0;
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // Signed three-pass accumulate.
    cyc(1'b1, 1'b0, 22'd100,    1'b1, 5'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 22'(-30),   1'b1, 5'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 22'd5,      1'b1, 5'd0, 1'b1, 1'b0);
    chk("three_pass", longint'(bus.out_data), 75);
    cyc(1'b0, 1'b0, 22'd0,      1'b1, 5'd0, 1'b1, 1'b1);

    // Single-beat vector table; each result is drained on the following idle cycle.
    for (int i = 0; i < 13; i++) begin
      cyc(1'b1, 1'b1, vecs[i].psum, vecs[i].sp, vecs[i].sh, vecs[i].so, 1'b1);
      chk($sformatf("vec%0d", i), longint'(bus.out_data), longint'(vecs[i].exp));
      cyc(1'b0, 1'b0, 22'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    end

    // Fill the FIFO with out_ready low, drop a fifth result, then drain in order.
    fill_exp = '{8'd10, 8'd20, 8'd30, 8'd40};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 22'(fill_exp[i]), 1'b1, 5'd0, 1'b1, 1'b0);
    end
    chk("full_not_ready", longint'(bus.psum_ready), 0);
    cyc(1'b1, 1'b1, 22'd50, 1'b1, 5'd0, 1'b1, 1'b0);
    chk("drop_overflow", longint'(bus.overflow), 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d", i), longint'(bus.out_data), longint'(fill_exp[i]));
      cyc(1'b0, 1'b0, 22'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    end
    chk("drained_empty", longint'(bus.out_valid), 0);
    chk("overflow_sticky", longint'(bus.overflow), 1);

    // Reset mid-accumulation with one queued entry.
    cyc(1'b1, 1'b1, 22'd9,   1'b1, 5'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 22'd200, 1'b1, 5'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 22'd300, 1'b1, 5'd0, 1'b1, 1'b0);
    do_reset();
    cyc(1'b1, 1'b1, 22'd7, 1'b1, 5'd0, 1'b1, 1'b0);
    chk("post_reset_result", longint'(bus.out_data), 7);
    cyc(1'b0, 1'b0, 22'd0, 1'b0, 5'd0, 1'b0, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rp = 22'($urandom);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, rp,
          1'($urandom), 5'($urandom_range(0, 14)), 1'($urandom),
          $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
